// File: rtl/div_40by8_seq.sv
// div_40by8_seq
//   Sequential unsigned divider: 40-bit dividend / 8-bit divisor ->
//   32-bit quotient + 8-bit remainder, restoring shift/subtract.
//   Intended to divide a registered 32x8 product back to its operand.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any operation)
//   start      request, sampled only when idle
//   dividend   40-bit unsigned dividend, captured at the accepting edge
//   divisor    8-bit unsigned divisor, captured at the accepting edge
//   busy       high while a division is in flight
//   done       one-cycle pulse when the result outputs update
//   quotient   low 32 bits of the quotient, held until the next done
//   remainder  8-bit remainder, held until the next done
//   ovf        true quotient >= 2^32 (held)
//   div0       divisor was zero (held)
//
// Build option:
//   DIV_RADIX4_EN  defined   -> two cascaded restoring steps per cycle
//                               (20 RUN cycles, 21-cycle latency)
//                  undefined -> one step per cycle (41-cycle latency)
module div_40by8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [39:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [7:0]  remainder,
  output logic        ovf,
  output logic        div0
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

`ifdef DIV_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam logic [5:0] LAST_CNT = 6'(40 / STEPS - 1);

  logic [1:0]  state_reg;
  logic [8:0]  rem_reg;        // partial remainder (always < divisor after a step)
  logic [39:0] q_reg;          // dividend shifts out the top, quotient bits enter the bottom
  logic [7:0]  dvs_reg;
  logic [5:0]  cnt_reg;
  logic        div0_pend_reg;

  logic        busy_reg;
  logic        done_reg;
  logic [31:0] quotient_reg;
  logic [7:0]  remainder_reg;
  logic        ovf_reg;
  logic        div0_reg;

  logic [8:0]  rem_next;
  logic [39:0] q_next;

  // STEPS cascaded restoring steps. The partial remainder entering a step
  // is below the divisor, so its bit 8 is zero and the shift never loses
  // information; trial bit 9 is the borrow of the subtraction.
  always_comb begin
    logic [8:0] shifted;
    logic [9:0] trial;
    rem_next = rem_reg;
    q_next   = q_reg;
    for (int i = 0; i < STEPS; i++) begin
      shifted = {rem_next[7:0], q_next[39]};
      trial   = {1'b0, shifted} - {2'b00, dvs_reg};
      if (trial[9]) begin
        rem_next = shifted;
        q_next   = {q_next[38:0], 1'b0};
      end else begin
        rem_next = trial[8:0];
        q_next   = {q_next[38:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rem_reg       <= '0;
      q_reg         <= '0;
      dvs_reg       <= '0;
      cnt_reg       <= '0;
      div0_pend_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      ovf_reg       <= 1'b0;
      div0_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            // Dividend is captured in both cases: the divide-by-zero
            // result reports its low byte as the remainder.
            q_reg   <= dividend;
            dvs_reg <= divisor;
            rem_reg <= '0;
            cnt_reg <= '0;
            if (divisor != 8'd0) begin
              div0_pend_reg <= 1'b0;
              busy_reg      <= 1'b1;
              state_reg     <= ST_RUN;
            end else begin
              div0_pend_reg <= 1'b1;
              state_reg     <= ST_FIN;
            end
          end
        end

        ST_RUN: begin
          rem_reg <= rem_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == LAST_CNT) begin
            state_reg <= ST_FIN;
          end
        end

        ST_FIN: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
          if (div0_pend_reg) begin
            quotient_reg  <= 32'hFFFF_FFFF;
            remainder_reg <= q_reg[7:0];
            ovf_reg       <= 1'b0;
            div0_reg      <= 1'b1;
          end else begin
            quotient_reg  <= q_reg[31:0];
            remainder_reg <= rem_reg[7:0];
            ovf_reg       <= |q_reg[39:32];
            div0_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign ovf       = ovf_reg;
  assign div0      = div0_reg;

endmodule

// File: tb/tb_div_40by8_seq.sv
// tb_div_40by8_seq
//   Directed self-checking bench for div_40by8_seq. Inputs are driven and
//   outputs sampled on the falling edge. Expected latency follows the
//   DIV_RADIX4_EN build option.
module tb_div_40by8_seq;

`ifdef DIV_RADIX4_EN
  localparam int LAT = 21;
`else
  localparam int LAT = 41;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [39:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        div0;

  int vectors = 0;
  int miscompares = 0;

  div_40by8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic launch(input logic [39:0] dd, input logic [7:0] dv);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Counts rising edges after the accepting edge until done is seen.
  task automatic wait_done(output int cyc, output bit timed_out, output bit busy_seen);
    cyc       = 0;
    timed_out = 1'b1;
    busy_seen = busy;
    for (int i = 0; i < 200 && timed_out; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_seen = 1'b1;
      if (done) timed_out = 1'b0;
    end
    $display("op done: cycles=%0d q=%h r=%h ovf=%b div0=%b", cyc, quotient, remainder, ovf, div0);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (quotient !== 32'd0)  begin miscompares++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    vectors++; if (remainder !== 8'd0)  begin miscompares++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    vectors++; if (ovf !== 1'b0)        begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    vectors++; if (div0 !== 1'b0)       begin miscompares++; $display("FAIL reset_div0: got %b want 0", div0); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc; bit to; bit bs;
    launch(40'd1000, 8'd7);
    wait_done(cyc, to, bs);
    vectors++; if (to)                   begin miscompares++; $display("FAIL basic_timeout: no done within bound"); end
    vectors++; if (cyc !== LAT)          begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", cyc, LAT); end
    vectors++; if (quotient !== 32'd142) begin miscompares++; $display("FAIL basic_quotient: got %0d want 142", quotient); end
    vectors++; if (remainder !== 8'd6)   begin miscompares++; $display("FAIL basic_remainder: got %0d want 6", remainder); end
    vectors++; if (ovf !== 1'b0)         begin miscompares++; $display("FAIL basic_ovf: got %b want 0", ovf); end
    vectors++; if (div0 !== 1'b0)        begin miscompares++; $display("FAIL basic_div0: got %b want 0", div0); end
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    vectors++; if (done !== 1'b0)        begin miscompares++; $display("FAIL basic_done_width: got %b want 0", done); end
    vectors++; if (quotient !== 32'd142) begin miscompares++; $display("FAIL basic_hold: got %0d want 142", quotient); end
  endtask

  task automatic test_round_trip;
    int cyc; bit to; bit bs;
    launch(40'h8F_85FC_100B, 8'hA5);
    wait_done(cyc, to, bs);
    vectors++; if (to)                          begin miscompares++; $display("FAIL rt_timeout: no done within bound"); end
    vectors++; if (quotient !== 32'hDEAD_BEEF)  begin miscompares++; $display("FAIL rt_quotient: got %h want deadbeef", quotient); end
    vectors++; if (remainder !== 8'd0)          begin miscompares++; $display("FAIL rt_remainder: got %h want 00", remainder); end
    vectors++; if (ovf !== 1'b0)                begin miscompares++; $display("FAIL rt_ovf: got %b want 0", ovf); end
    @(negedge clk);
  endtask

  task automatic test_div0;
    int cyc; bit to; bit bs;
    launch(40'h12_3456_789A, 8'd0);
    wait_done(cyc, to, bs);
    vectors++; if (to)                          begin miscompares++; $display("FAIL div0_timeout: no done within bound"); end
    vectors++; if (cyc !== 1)                   begin miscompares++; $display("FAIL div0_latency: got %0d want 1", cyc); end
    vectors++; if (bs !== 1'b0)                 begin miscompares++; $display("FAIL div0_busy: got %b want 0", bs); end
    vectors++; if (div0 !== 1'b1)               begin miscompares++; $display("FAIL div0_flag: got %b want 1", div0); end
    vectors++; if (quotient !== 32'hFFFF_FFFF)  begin miscompares++; $display("FAIL div0_quotient: got %h want ffffffff", quotient); end
    vectors++; if (remainder !== 8'h9A)         begin miscompares++; $display("FAIL div0_remainder: got %h want 9a", remainder); end
    vectors++; if (ovf !== 1'b0)                begin miscompares++; $display("FAIL div0_ovf: got %b want 0", ovf); end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int cyc; bit to; bit bs;
    launch(40'hFF_0000_0001, 8'h01);
    wait_done(cyc, to, bs);
    vectors++; if (to)                  begin miscompares++; $display("FAIL ovf_timeout: no done within bound"); end
    vectors++; if (ovf !== 1'b1)        begin miscompares++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    vectors++; if (quotient !== 32'd1)  begin miscompares++; $display("FAIL ovf_quotient: got %h want 00000001", quotient); end
    vectors++; if (remainder !== 8'd0)  begin miscompares++; $display("FAIL ovf_remainder: got %h want 00", remainder); end
    vectors++; if (div0 !== 1'b0)       begin miscompares++; $display("FAIL ovf_div0: got %b want 0", div0); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int ndone = 0; int first_cyc = -1;
    logic [31:0] q_cap = '0; logic [7:0] r_cap = '0;
    launch(40'd1000, 8'd7);
    for (int i = 1; i <= LAT + 10; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_cyc < 0) begin first_cyc = i; q_cap = quotient; r_cap = remainder; end
      end
      if (i == 10) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ign_busy_mid: got %b want 1", busy); end
        start = 1'b1; dividend = 40'd500; divisor = 8'd3;
      end else begin
        start = 1'b0;
      end
    end
    $display("op ignored-start: dones=%0d first=%0d q=%h r=%h", ndone, first_cyc, q_cap, r_cap);
    vectors++; if (ndone !== 1)        begin miscompares++; $display("FAIL ign_done_count: got %0d want 1", ndone); end
    vectors++; if (first_cyc !== LAT)  begin miscompares++; $display("FAIL ign_latency: got %0d want %0d", first_cyc, LAT); end
    vectors++; if (q_cap !== 32'd142)  begin miscompares++; $display("FAIL ign_quotient: got %0d want 142", q_cap); end
    vectors++; if (r_cap !== 8'd6)     begin miscompares++; $display("FAIL ign_remainder: got %0d want 6", r_cap); end
  endtask

  task automatic test_back_to_back;
    int cyc; bit to; bit bs;
    launch(40'd1000, 8'd7);
    wait_done(cyc, to, bs);
    vectors++; if (quotient !== 32'd142) begin miscompares++; $display("FAIL b2b_first_quotient: got %0d want 142", quotient); end
    // Start issued in the done cycle itself.
    launch(40'd255, 8'd16);
    wait_done(cyc, to, bs);
    vectors++; if (to)                   begin miscompares++; $display("FAIL b2b_timeout: no done within bound"); end
    vectors++; if (cyc !== LAT)          begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT); end
    vectors++; if (quotient !== 32'd15)  begin miscompares++; $display("FAIL b2b_quotient: got %0d want 15", quotient); end
    vectors++; if (remainder !== 8'd15)  begin miscompares++; $display("FAIL b2b_remainder: got %0d want 15", remainder); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int cyc; bit to; bit bs; int ndone = 0;
    launch(40'd1000, 8'd7);
    repeat (LAT / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL rmid_done: got %b want 0", done); end
    vectors++; if (quotient !== 32'd0)  begin miscompares++; $display("FAIL rmid_quotient: got %h want 0", quotient); end
    vectors++; if (remainder !== 8'd0)  begin miscompares++; $display("FAIL rmid_remainder: got %h want 0", remainder); end
    vectors++; if (ovf !== 1'b0)        begin miscompares++; $display("FAIL rmid_ovf: got %b want 0", ovf); end
    vectors++; if (div0 !== 1'b0)       begin miscompares++; $display("FAIL rmid_div0: got %b want 0", div0); end
    repeat (LAT + 10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    $display("op reset-abort: dones after abort=%0d", ndone);
    vectors++; if (ndone !== 0)         begin miscompares++; $display("FAIL rmid_spurious_done: got %0d want 0", ndone); end
    launch(40'd1000, 8'd7);
    wait_done(cyc, to, bs);
    vectors++; if (to)                   begin miscompares++; $display("FAIL rmid_fresh_timeout: no done within bound"); end
    vectors++; if (cyc !== LAT)          begin miscompares++; $display("FAIL rmid_fresh_latency: got %0d want %0d", cyc, LAT); end
    vectors++; if (quotient !== 32'd142) begin miscompares++; $display("FAIL rmid_fresh_quotient: got %0d want 142", quotient); end
    vectors++; if (remainder !== 8'd6)   begin miscompares++; $display("FAIL rmid_fresh_remainder: got %0d want 6", remainder); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_trip();
    test_div0();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_40by8_seq.md
# div_40by8_seq

Sequential unsigned divider that inverts the registered 32×8 multiply path of the add/multiply datapath. It takes a 40-bit product-width dividend and an 8-bit divisor and returns a 32-bit quotient and 8-bit remainder, so that a value produced by the multiplier can be divided back down to its 32-bit operand. The block uses one restoring shift/subtract step per cycle, a start/done handshake, and flags for divide-by-zero and quotient overflow. It sits beside the add/multiply top and consumes its registered 40-bit result.

## Interface
Parameters: none. Widths are fixed at 40/8/32/8.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  40  unsigned dividend; sampled at the accepting edge.
- divisor  in  8  unsigned divisor; sampled at the accepting edge.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when results update.
- quotient  out  32  low 32 bits of the quotient; held until the next done.
- remainder  out  8  remainder; held until the next done.
- ovf  out  1  the true quotient is ≥ 2^32; valid with done, held afterwards.
- div0  out  1  the divisor was zero; valid with done, held afterwards.

## Operation
- Reset values: state IDLE; busy=0, done=0, quotient=0, remainder=0, ovf=0, div0=0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - When start=1 and divisor≠0: latch the dividend into the shift register, latch the divisor, clear the 9-bit partial remainder, set the step count to 0, go to RUN, set busy=1.
  - When start=1 and divisor=0: go to FIN directly with div0 pending.
- RUN, once per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial value = partial remainder − {1'b0, divisor}.
  - If the trial value is non-negative, keep it and shift in quotient bit 1; otherwise restore the partial remainder and shift in 0.
  - After 40 steps go to FIN.
- FIN (one cycle):
  - Load quotient = q[31:0] and remainder = the final partial remainder.
  - Load ovf = |q[39:32].
  - Load div0.
  - Assert done; deassert busy; return to IDLE.
- Divide-by-zero result: quotient=32'hFFFF_FFFF, remainder=dividend[7:0], ovf=0, div0=1.
- start while busy=1 is ignored. No queueing; the dividend and divisor inputs are don't-care.
- start in the cycle that done=1 is accepted, because the FSM is already back in IDLE.
- rst asserted mid-operation aborts the operation:
  - All outputs take their reset values at that edge.
  - No done pulse is produced for the aborted operation.
  - Any partial result is discarded.
- All arithmetic is unsigned. No signed mode.

## Timing
- Accepting edge k (IDLE, start=1, divisor≠0):
  - busy=1 from edge k.
  - The RUN steps take edges k+1 … k+40.
  - FIN outputs (done=1, busy=0, new results) appear after edge k+41.
  - Start-to-done latency: 41 cycles.
- divisor=0: done=1 after edge k+1. Latency 1 cycle; busy stays 0.
- done is high for exactly one cycle. The result outputs are stable until the next done or until rst.
- The earliest back-to-back start is the done cycle itself, giving a throughput of one operation per 42 cycles (radix-2).

## Configuration
- Macro DIV_RADIX4_EN.
- Defined: each RUN cycle retires 2 quotient bits, using two cascaded restoring steps in one cycle.
  - The RUN phase is 20 cycles; start-to-done latency is 21 cycles.
  - Results are identical to radix-2.
- Undefined: radix-2, one bit per cycle, 41-cycle latency.
- The divide-by-zero path (1 cycle) is the same in both builds.

## Test plan
- Basic divide: dividend=40'd1000, divisor=8'd7.
  - Expect quotient=32'd142, remainder=8'd6, ovf=0, div0=0.
  - done exactly 41 cycles after start (21 with DIV_RADIX4_EN).
- Round trip: dividend=40'h8F_85FC_100B (0xDEADBEEF×0xA5), divisor=8'hA5.
  - Expect quotient=32'hDEAD_BEEF, remainder=0.
- Divide-by-zero: dividend=40'h12_3456_789A, divisor=0.
  - Expect done one cycle after start, div0=1, quotient=32'hFFFF_FFFF, remainder=8'h9A, busy never high.
- Overflow: dividend=40'hFF_0000_0001, divisor=8'h01.
  - Expect ovf=1, quotient=32'h0000_0001, remainder=0.
- Ignored start and back-to-back start:
  - Pulse start at cycle 10 of a run with different operands: the first result is unchanged and there is exactly one done.
  - A start in the done cycle is accepted and its done arrives 41 cycles later.
- Reset mid-run: assert rst at RUN step 20.
  - Expect all outputs zero at the next edge.
  - Expect no done for the aborted operation.
  - A fresh 1000/7 afterwards completes correctly.
